// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps fetch (T0-T2) and execute (T3-T5) from a
// registered state and drives the datapath register-transfer strobes.
module control_sequencer #(
    parameter int OPCODE_W     = 5,
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Run,
    input  logic [31:0]         IR,
    input  logic                Mem_ack,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                MARin,
    output logic                ZLowIn,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OPCODE_W-1:0] ALU_op,
    output logic                Busy,
    output logic                Halted,
    output logic [1:0]          Fault,
    output logic [CNT_W-1:0]    Instr_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_HALT  = 4'd7;
    localparam logic [3:0] ST_FAULT = 4'd8;

    localparam logic [OPCODE_W-1:0] OP_ALU_LAST = OPCODE_W'(5'b01010);
    localparam logic [OPCODE_W-1:0] OP_NOP      = OPCODE_W'(5'b11010);
    localparam logic [OPCODE_W-1:0] OP_HALT     = OPCODE_W'(5'b11011);

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [OPCODE_W-1:0] opcode;
    logic                is_alu;
    logic                is_nop;
    logic                is_halt;
    logic                retire;
    logic                unused_ir_fields;

    // Register-select fields are decoded by the datapath, not here
    assign unused_ir_fields = ^IR[31-OPCODE_W:0];

    assign opcode  = IR[31 -: OPCODE_W];
    assign is_alu  = (opcode <= OP_ALU_LAST);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign retire  = (state == ST_T5) || ((state == ST_T3) && (is_nop || is_halt));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (Run) next_state = ST_T0;
            ST_T0:    next_state = ST_T1;
            ST_T1: begin
                if (Mem_ack)
                    next_state = ST_T2;
                else if (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1))
                    next_state = ST_FAULT;
            end
            ST_T2:    next_state = ST_T3;
            ST_T3: begin
                if (is_alu)       next_state = ST_T4;
                else if (is_nop)  next_state = Run ? ST_T0 : ST_IDLE;
                else if (is_halt) next_state = ST_HALT;
                else              next_state = ST_FAULT;
            end
            ST_T4:    next_state = ST_T5;
            ST_T5:    next_state = Run ? ST_T0 : ST_IDLE;
            ST_HALT:  next_state = ST_HALT;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_IDLE;
        endcase
    end

    // wait_cnt counts T1 cycles already spent without Mem_ack; zero on T1 entry
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            Fault       <= 2'd0;
            Instr_count <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_T1) && (next_state == ST_T1))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if ((state == ST_T1) && (next_state == ST_FAULT))
                Fault <= 2'd2;
            else if ((state == ST_T3) && (next_state == ST_FAULT))
                Fault <= 2'd1;
            if (retire)
                Instr_count <= Instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        ZLowIn  = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        ALU_op  = '0;
        case (state)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = (wait_cnt == '0);
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                Grb  = is_alu;
                Rout = is_alu;
                Yin  = is_alu;
            end
            ST_T4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                ZLowIn = 1'b1;
                ALU_op = opcode;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy   = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT);
    assign Halted = (state == ST_HALT);

endmodule
